// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: RV32I memory width codes and FSM states.
package load_store_unit_pkg;

  localparam logic [2:0] MEM_W_B  = 3'b000;
  localparam logic [2:0] MEM_W_H  = 3'b001;
  localparam logic [2:0] MEM_W_W  = 3'b010;
  localparam logic [2:0] MEM_W_BU = 3'b100;
  localparam logic [2:0] MEM_W_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte enables, store-data replication, legality
// flags and load-data extraction/extension for one access.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Unsigned widths exist only for loads, so BU/HU with a store are illegal.
  always_comb begin
    be         = 4'b0000;
    store_data = wdata;
    load_data  = mem_rdata;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      MEM_W_B: begin
        be         = 4'b0001 << addr_lo;
        store_data = {4{wdata[7:0]}};
        load_data  = {{24{byte_sel[7]}}, byte_sel};
      end
      MEM_W_H: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
        load_data  = {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      MEM_W_W: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      MEM_W_BU: begin
        be        = 4'b0001 << addr_lo;
        load_data = {24'd0, byte_sel};
        illegal   = is_store;
      end
      MEM_W_HU: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data  = {16'd0, half_sel};
        misaligned = addr_lo[0];
        illegal    = is_store;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory load/store unit: legality check, req/ack handshake with a
// variable-latency memory, timeout abort and aligned load-data return.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state, state_next;
  logic [7:0]  timer;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_addr_lo;
  logic        lat_store;
  logic [2:0]  sel_funct3;
  logic [1:0]  sel_addr_lo;
  logic        sel_store;
  logic [3:0]  al_be;
  logic [31:0] al_store_data;
  logic [31:0] al_load_data;
  logic        al_misaligned;
  logic        al_illegal;
  logic        accept;
  logic        err_next;
  logic        timed_out;

  // One aligner serves both directions: live inputs while idle, latched access afterwards.
  always_comb begin
    sel_funct3  = (state == IDLE) ? funct3    : lat_funct3;
    sel_addr_lo = (state == IDLE) ? addr[1:0] : lat_addr_lo;
    sel_store   = (state == IDLE) ? is_store  : lat_store;
  end

  lsu_align u_align (
    .funct3     (sel_funct3),
    .addr_lo    (sel_addr_lo),
    .is_store   (sel_store),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .be         (al_be),
    .store_data (al_store_data),
    .load_data  (al_load_data),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  assign timed_out = (timer == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      err   <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (al_misaligned || al_illegal) begin
            err_next = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = lat_store;
        if (mem_ack) begin
          state_next = RESP;
        end else if (timed_out) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
      RESP: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured only for accepted accesses so a rejected start leaves the bus untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer       <= 8'd0;
      lat_funct3  <= 3'd0;
      lat_addr_lo <= 2'd0;
      lat_store   <= 1'b0;
      mem_addr    <= 32'd0;
      mem_be      <= 4'd0;
      mem_wdata   <= 32'd0;
      rdata       <= 32'd0;
    end else begin
      if (state == IDLE && start) begin
        timer       <= 8'd0;
        lat_funct3  <= funct3;
        lat_addr_lo <= addr[1:0];
        lat_store   <= is_store;
      end else if (state == REQ) begin
        timer <= timer + 8'd1;
      end
      if (accept) begin
        mem_addr  <= {addr[31:2], 2'b00};
        mem_be    <= al_be;
        mem_wdata <= al_store_data;
      end
      if (state == REQ && mem_ack && !lat_store) begin
        rdata <= al_load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table with a scoreboard of
// expected completions, plus hand-written reset and double-start sequences.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  typedef struct {
    logic        isStore;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memData;
    int          ackDelay;
    logic        expErr;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
  } vec_t;

  typedef struct {
    logic        expErr;
    logic [31:0] expRdata;
    int          expReqCycles;
  } sb_t;

  sb_t         sbQueue[$];
  vec_t        vecs[17];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] modelRdata = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    sb_t e;
    sb_t got;
    int  reqCycles;
    int  cycles;
    bit  finished;
    bit  busChecked;
    @(negedge clk);
    is_store = v.isStore;
    funct3   = v.f3;
    addr     = v.addr;
    wdata    = v.wdata;
    start    = 1'b1;
    e.expErr       = v.expErr;
    e.expRdata     = (v.isStore || v.expErr) ? modelRdata : v.expRdata;
    e.expReqCycles = v.expErr ? ((v.ackDelay < 0) ? TIMEOUT : 0) : v.ackDelay + 1;
    modelRdata     = e.expRdata;
    sbQueue.push_back(e);
    @(negedge clk);
    start = 1'b0;
    addr  = $urandom;
    wdata = $urandom;
    reqCycles  = 0;
    cycles     = 0;
    finished   = 1'b0;
    busChecked = 1'b0;
    while (!finished && cycles < 64) begin
      if (done || err) begin
        checkOutput($sformatf("v%0d done_err_overlap", idx), 32'(done && err), 32'd0);
        checkOutput($sformatf("v%0d busy_at_end", idx), 32'(busy), 32'd0);
        checkOutput($sformatf("v%0d mem_req_at_end", idx), 32'(mem_req), 32'd0);
        if (sbQueue.size() == 0) begin
          checkOutput($sformatf("v%0d scoreboard_empty", idx), 32'd1, 32'd0);
        end else begin
          got = sbQueue.pop_front();
          checkOutput($sformatf("v%0d err", idx), 32'(err), 32'(got.expErr));
          checkOutput($sformatf("v%0d rdata", idx), rdata, got.expRdata);
          checkOutput($sformatf("v%0d req_cycles", idx), 32'(reqCycles), 32'(got.expReqCycles));
        end
        finished = 1'b1;
      end else begin
        if (mem_req) begin
          if (!busChecked) begin
            checkOutput($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
            checkOutput($sformatf("v%0d mem_addr", idx), mem_addr, v.expAddr);
            checkOutput($sformatf("v%0d mem_be", idx), 32'(mem_be), 32'(v.expBe));
            checkOutput($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.isStore));
            if (v.isStore) checkOutput($sformatf("v%0d mem_wdata", idx), mem_wdata, v.expWdata);
            busChecked = 1'b1;
          end
          mem_ack   = (v.ackDelay >= 0) && (reqCycles == v.ackDelay);
          mem_rdata = mem_ack ? v.memData : $urandom;
          reqCycles++;
        end
        @(negedge clk);
        mem_ack = 1'b0;
        cycles++;
      end
    end
    if (!finished) checkOutput($sformatf("v%0d completion_timeout", idx), 32'd1, 32'd0);
    @(negedge clk);
    checkOutput($sformatf("v%0d pulse_one_cycle", idx), 32'({done, err}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneCount;
    int errCount;
    int reqCount;

    vecs[0]  = '{1'b0, MEM_W_B,  32'h103, 32'h0,        32'h80AABBCC, 3,  1'b0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80};
    vecs[1]  = '{1'b1, MEM_W_H,  32'h22,  32'h1234ABCD, 32'h0,        0,  1'b0, 32'h20,  4'b1100, 32'hABCDABCD, 32'h0};
    vecs[2]  = '{1'b0, MEM_W_W,  32'h41,  32'h0,        32'h0,        0,  1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, MEM_W_H,  32'h06,  32'h0,        32'h80017FFF, 1,  1'b0, 32'h04,  4'b1100, 32'h0,        32'hFFFF8001};
    vecs[4]  = '{1'b0, MEM_W_HU, 32'h04,  32'h0,        32'h8001F0F0, 2,  1'b0, 32'h04,  4'b0011, 32'h0,        32'h0000F0F0};
    vecs[5]  = '{1'b0, MEM_W_BU, 32'h02,  32'h0,        32'h11CC2233, 0,  1'b0, 32'h00,  4'b0100, 32'h0,        32'h000000CC};
    vecs[6]  = '{1'b0, MEM_W_B,  32'h01,  32'h0,        32'h00007F00, 1,  1'b0, 32'h00,  4'b0010, 32'h0,        32'h0000007F};
    vecs[7]  = '{1'b1, MEM_W_B,  32'h03,  32'hDEADBE5A, 32'h0,        2,  1'b0, 32'h00,  4'b1000, 32'h5A5A5A5A, 32'h0};
    vecs[8]  = '{1'b1, MEM_W_W,  32'h10,  32'hCAFEF00D, 32'h0,        0,  1'b0, 32'h10,  4'b1111, 32'hCAFEF00D, 32'h0};
    vecs[9]  = '{1'b0, MEM_W_W,  32'h08,  32'h0,        32'h89ABCDEF, 4,  1'b0, 32'h08,  4'b1111, 32'h0,        32'h89ABCDEF};
    vecs[10] = '{1'b1, MEM_W_H,  32'h23,  32'h5555AAAA, 32'h0,        0,  1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1'b1, MEM_W_W,  32'h12,  32'h5555AAAA, 32'h0,        0,  1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 3'b011,   32'h00,  32'h0,        32'h0,        0,  1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[13] = '{1'b1, MEM_W_BU, 32'h00,  32'h000000AA, 32'h0,        0,  1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[14] = '{1'b0, 3'b110,   32'h00,  32'h0,        32'h0,        0,  1'b1, 32'h0,   4'b0000, 32'h0,        32'h0};
    vecs[15] = '{1'b0, MEM_W_HU, 32'h0E,  32'h0,        32'h0,        -1, 1'b1, 32'h0C,  4'b1100, 32'h0,        32'h0};
    vecs[16] = '{1'b0, MEM_W_W,  32'h00,  32'h0,        32'h13572468, 0,  1'b0, 32'h00,  4'b1111, 32'h0,        32'h13572468};

    reset     = 1'b0;
    start     = 1'b0;
    is_store  = 1'b0;
    funct3    = 3'd0;
    addr      = 32'd0;
    wdata     = 32'd0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset err", 32'(err), 32'd0);
    checkOutput("reset mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset mem_addr", mem_addr, 32'd0);
    checkOutput("reset mem_be", 32'(mem_be), 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset rdata", rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) applyStimulus(vecs[i], i);

    // Reset asserted mid-request must clear outputs without a clock edge.
    @(negedge clk);
    is_store = 1'b0;
    funct3   = MEM_W_W;
    addr     = 32'h40;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rst_mid mem_req_before", 32'(mem_req), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_mid mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mid busy", 32'(busy), 32'd0);
    checkOutput("rst_mid done", 32'(done), 32'd0);
    checkOutput("rst_mid mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mid mem_be", 32'(mem_be), 32'd0);
    checkOutput("rst_mid rdata", rdata, 32'd0);
    modelRdata = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus('{1'b0, MEM_W_BU, 32'h01, 32'h0, 32'h0000FF00, 0, 1'b0, 32'h00, 4'b0010, 32'h0, 32'h000000FF}, 100);

    // A second start during REQ must not disturb the access in flight.
    @(negedge clk);
    is_store = 1'b0;
    funct3   = MEM_W_W;
    addr     = 32'h80;
    start    = 1'b1;
    @(negedge clk);
    doneCount = 0;
    errCount  = 0;
    reqCount  = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) doneCount++;
      if (err) errCount++;
      start    = (c < 2);
      is_store = 1'b1;
      funct3   = MEM_W_B;
      addr     = 32'h200;
      if (mem_req) begin
        checkOutput($sformatf("dbl mem_addr c%0d", c), mem_addr, 32'h80);
        checkOutput($sformatf("dbl mem_we c%0d", c), 32'(mem_we), 32'd0);
        mem_ack   = (reqCount == 2);
        mem_rdata = mem_ack ? 32'hA5A55A5A : $urandom;
        reqCount++;
      end else if (c == 7) begin
        mem_ack = 1'b1;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    checkOutput("dbl done_count", 32'(doneCount), 32'd1);
    checkOutput("dbl err_count", 32'(errCount), 32'd0);
    checkOutput("dbl req_cycles", 32'(reqCount), 32'd3);
    checkOutput("dbl rdata", rdata, 32'hA5A55A5A);
    checkOutput("scoreboard drained", 32'(sbQueue.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
